// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-requester program/data memory arbiter.
package mem_arb_pkg;

  localparam int unsigned AW_DEF       = 5;
  localparam int unsigned DW_DEF       = 8;
  localparam int unsigned MAX_HOLD_DEF = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_OWN  = 2'd1,
    HOST_OWN = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_CPU  = 1'b0,
    OWN_HOST = 1'b1
  } owner_t;

  // Bits needed to hold a count that saturates at max_hold.
  function automatic int unsigned hold_cw(input int unsigned max_hold);
    return (max_hold < 1) ? 1 : $clog2(max_hold + 1);
  endfunction

endpackage

// File: rtl/mem_arb_hold_ctr.sv
// Saturating count of consecutive owner access cycles; clear wins over enable.
module mem_arb_hold_ctr
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEF,
  parameter int unsigned CW       = hold_cw(MAX_HOLD)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [CW-1:0] o_cnt
);

  localparam logic [CW-1:0] SAT = CW'(MAX_HOLD);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != SAT)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving a CPU datapath and a host loader turns on one
// single-port memory. Optional host lock ownership: define MEM_ARB_LOCK_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW       = AW_DEF,
  parameter int unsigned DW       = DW_DEF,
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_valid,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          host_valid,
  input  logic          host_lock,
  output logic [DW-1:0] rd_data,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned   CW        = hold_cw(MAX_HOLD);
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  arb_state_t    r_state;
  arb_state_t    w_state_nxt;
  owner_t        r_last;
  logic          r_cpu_gnt;
  logic          r_host_gnt;
  logic          r_cpu_valid;
  logic          r_host_valid;
  logic [DW-1:0] r_rd_data;
  logic [CW-1:0] w_cnt;
  logic          w_cpu_acc;
  logic          w_host_acc;
  logic          w_cpu_rd;
  logic          w_host_rd;
  logic          w_hold_done;
  logic          w_own_chg;
  logic          w_host_locked;

  assign w_cpu_acc   = (r_state == CPU_OWN)  && cpu_req;
  assign w_host_acc  = (r_state == HOST_OWN) && host_req;
  assign w_cpu_rd    = w_cpu_acc  && !cpu_we;
  assign w_host_rd   = w_host_acc && !host_we;
  // >= so a counter that saturated while the other side was idle still hands over.
  assign w_hold_done = (w_cnt >= HOLD_LAST);
  assign w_own_chg   = (w_state_nxt != r_state);

`ifdef MEM_ARB_LOCK_EN
  assign w_host_locked = host_lock;
`else
  // host_lock has no effect in this build; the AND keeps the port referenced.
  assign w_host_locked = 1'b0 & host_lock;
`endif

  mem_arb_hold_ctr #(
    .MAX_HOLD (MAX_HOLD),
    .CW       (CW)
  ) u_hold_ctr (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_own_chg),
    .i_en  (w_cpu_acc || w_host_acc),
    .o_cnt (w_cnt)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (cpu_req && host_req) begin
          w_state_nxt = (r_last == OWN_HOST) ? CPU_OWN : HOST_OWN;
        end else if (cpu_req) begin
          w_state_nxt = CPU_OWN;
        end else if (host_req) begin
          w_state_nxt = HOST_OWN;
        end
      end
      CPU_OWN: begin
        if (!cpu_req) begin
          w_state_nxt = host_req ? HOST_OWN : IDLE;
        end else if (host_req && w_hold_done) begin
          w_state_nxt = HOST_OWN;
        end
      end
      HOST_OWN: begin
        if (!host_req) begin
          w_state_nxt = cpu_req ? CPU_OWN : IDLE;
        end else if (cpu_req && w_hold_done && !w_host_locked) begin
          w_state_nxt = CPU_OWN;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    unique case (r_state)
      CPU_OWN: begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = cpu_req && cpu_we;
      end
      HOST_OWN: begin
        mem_addr  = host_addr;
        mem_wdata = host_wdata;
        mem_we    = host_req && host_we;
      end
      default: ;
    endcase
  end

  // rd_data is the memory's output register: it captures the array read at the
  // end of the access cycle, so data and valid appear together one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last       <= OWN_HOST;
      r_cpu_gnt    <= 1'b0;
      r_host_gnt   <= 1'b0;
      r_cpu_valid  <= 1'b0;
      r_host_valid <= 1'b0;
      r_rd_data    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cpu_gnt    <= (w_state_nxt == CPU_OWN);
      r_host_gnt   <= (w_state_nxt == HOST_OWN);
      r_cpu_valid  <= w_cpu_rd;
      r_host_valid <= w_host_rd;
      if (w_own_chg && (w_state_nxt == CPU_OWN)) begin
        r_last <= OWN_CPU;
      end else if (w_own_chg && (w_state_nxt == HOST_OWN)) begin
        r_last <= OWN_HOST;
      end
      if (w_cpu_rd || w_host_rd) begin
        r_rd_data <= mem_rdata;
      end
    end
  end

  assign cpu_gnt    = r_cpu_gnt;
  assign host_gnt   = r_host_gnt;
  assign cpu_valid  = r_cpu_valid;
  assign host_valid = r_host_valid;
  assign rd_data    = r_rd_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural 32x8 memory.
module tb_mem_arbiter;

  localparam int AW = 5;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt, cpu_valid;
  logic          host_req, host_we, host_lock;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_gnt, host_valid;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] mem [32];
  logic          mem_load;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_valid  (cpu_valid),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_gnt   (host_gnt),
    .host_valid (host_valid),
    .host_lock  (host_lock),
    .rd_data    (rd_data),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  function automatic logic [DW-1:0] init_val(input int i);
    return (i == 5) ? 8'h3C : 8'(8'h10 + i);
  endfunction

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_val(i);
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0; host_lock = 0;
  endtask

  // Leaves the bench just after a rising edge with reset released: cycle 0.
  task automatic do_reset();
    reset = 1;
    idle_inputs();
    next_cyc();
    next_cyc();
    reset = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  nwe;
    bit  exp_host;
    mem_load = 1;
    do_reset();
    mem_load = 0;

    // Reset state
    check_eq("rst_cpu_gnt",    cpu_gnt,    0);
    check_eq("rst_host_gnt",   host_gnt,   0);
    check_eq("rst_cpu_valid",  cpu_valid,  0);
    check_eq("rst_host_valid", host_valid, 0);
    check_eq("rst_rd_data",    rd_data,    0);
    check_eq("rst_mem_we",     mem_we,     0);
    check_eq("rst_mem_addr",   mem_addr,   0);

    // Single CPU read of address 5
    cpu_req = 1; cpu_addr = 5;
    @(negedge clk);
    check_eq("rd_c0_cpu_gnt", cpu_gnt, 0);
    next_cyc(); @(negedge clk);
    check_eq("rd_c1_cpu_gnt",   cpu_gnt,   1);
    check_eq("rd_c1_mem_addr",  mem_addr,  5);
    check_eq("rd_c1_mem_we",    mem_we,    0);
    check_eq("rd_c1_cpu_valid", cpu_valid, 0);
    next_cyc(); cpu_req = 0; @(negedge clk);
    check_eq("rd_c2_cpu_valid",  cpu_valid,  1);
    check_eq("rd_c2_rd_data",    rd_data,    8'h3C);
    check_eq("rd_c2_host_valid", host_valid, 0);
    next_cyc(); @(negedge clk);
    check_eq("rd_c3_cpu_gnt",   cpu_gnt,   0);
    check_eq("rd_c3_cpu_valid", cpu_valid, 0);
    check_eq("rd_c3_mem_addr",  mem_addr,  0);

    // Both request together: CPU first, alternate every 4 accesses
    do_reset();
    cpu_req = 1; host_req = 1; cpu_addr = 1; host_addr = 2;
    @(negedge clk);
    check_eq("rr_c0_cpu_gnt",  cpu_gnt,  0);
    check_eq("rr_c0_host_gnt", host_gnt, 0);
    for (int k = 1; k <= 16; k++) begin
      next_cyc(); @(negedge clk);
      check_eq($sformatf("rr_cpu_gnt[%0d]", k),  cpu_gnt,  ((k - 1) / 4) % 2 == 0);
      check_eq($sformatf("rr_host_gnt[%0d]", k), host_gnt, ((k - 1) / 4) % 2 == 1);
      if (k == 2) begin
        check_eq("rr_c2_cpu_valid", cpu_valid, 1);
        check_eq("rr_c2_rd_data",   rd_data,   8'h11);
      end
      if (k == 6) begin
        check_eq("rr_c6_host_valid", host_valid, 1);
        check_eq("rr_c6_cpu_valid",  cpu_valid,  0);
        check_eq("rr_c6_rd_data",    rd_data,    8'h12);
      end
    end
    idle_inputs();

    // Host writes 0xA5 to 31, CPU reads it back; then tie goes to host
    do_reset();
    nwe = 0;
    host_req = 1; host_we = 1; host_addr = 31; host_wdata = 8'hA5;
    @(negedge clk); nwe += int'(mem_we);
    next_cyc(); @(negedge clk);
    check_eq("wr_c1_host_gnt",  host_gnt,  1);
    check_eq("wr_c1_mem_we",    mem_we,    1);
    check_eq("wr_c1_mem_addr",  mem_addr,  31);
    check_eq("wr_c1_mem_wdata", mem_wdata, 8'hA5);
    nwe += int'(mem_we);
    next_cyc(); host_req = 0; host_we = 0; cpu_req = 1; cpu_addr = 31;
    @(negedge clk);
    check_eq("wr_c2_host_valid", host_valid, 0);
    nwe += int'(mem_we);
    next_cyc(); @(negedge clk);
    check_eq("wr_c3_cpu_gnt",  cpu_gnt,  1);
    check_eq("wr_c3_mem_addr", mem_addr, 31);
    nwe += int'(mem_we);
    next_cyc(); cpu_req = 0; @(negedge clk);
    check_eq("wr_c4_cpu_valid", cpu_valid, 1);
    check_eq("wr_c4_rd_data",   rd_data,   8'hA5);
    nwe += int'(mem_we);
    check_eq("wr_we_pulses", nwe, 1);
    next_cyc(); cpu_req = 1; host_req = 1; @(negedge clk);
    check_eq("tie_c5_cpu_gnt",  cpu_gnt,  0);
    check_eq("tie_c5_host_gnt", host_gnt, 0);
    next_cyc(); @(negedge clk);
    check_eq("tie_c6_host_gnt", host_gnt, 1);
    check_eq("tie_c6_cpu_gnt",  cpu_gnt,  0);
    idle_inputs();

    // Reset during a CPU read
    do_reset();
    cpu_req = 1; cpu_addr = 5;
    next_cyc(); reset = 1; @(negedge clk);
    check_eq("rmid_c1_cpu_gnt", cpu_gnt, 1);
    next_cyc(); reset = 0; @(negedge clk);
    check_eq("rmid_c2_cpu_valid", cpu_valid, 0);
    check_eq("rmid_c2_cpu_gnt",   cpu_gnt,   0);
    check_eq("rmid_c2_host_gnt",  host_gnt,  0);
    check_eq("rmid_c2_rd_data",   rd_data,   0);
    next_cyc(); @(negedge clk);
    check_eq("rmid_c3_cpu_gnt", cpu_gnt, 1);
    idle_inputs();

    // Host lock while both request
    do_reset();
    host_req = 1; host_lock = 1; host_addr = 3;
    for (int k = 1; k <= 10; k++) begin
      next_cyc();
      if (k == 1) cpu_req = 1;
      @(negedge clk);
`ifdef MEM_ARB_LOCK_EN
      exp_host = 1'b1;
`else
      exp_host = (k <= 4) || (k >= 9);
`endif
      check_eq($sformatf("lock_host_gnt[%0d]", k), host_gnt, exp_host);
      check_eq($sformatf("lock_cpu_gnt[%0d]", k),  cpu_gnt,  !exp_host);
    end
    idle_inputs();

    // Sole requester keeps ownership; saturated counter still hands over
    do_reset();
    cpu_req = 1; cpu_addr = 7;
    for (int k = 1; k <= 8; k++) begin
      next_cyc(); @(negedge clk);
      check_eq($sformatf("sat_cpu_gnt[%0d]", k),  cpu_gnt,  1);
      check_eq($sformatf("sat_host_gnt[%0d]", k), host_gnt, 0);
    end
    next_cyc(); host_req = 1; @(negedge clk);
    check_eq("sat_c9_cpu_gnt",   cpu_gnt,   1);
    check_eq("sat_c9_cpu_valid", cpu_valid, 1);
    check_eq("sat_c9_rd_data",   rd_data,   8'h17);
    next_cyc(); @(negedge clk);
    check_eq("sat_c10_host_gnt", host_gnt, 1);
    check_eq("sat_c10_cpu_gnt",  cpu_gnt,  0);
    idle_inputs();
    next_cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
